// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
//
// Captures the decoded instruction (PC+4, immediate, register operands, register addresses,
// ALU op and control bits) on each rising ie_clk edge and presents it to the execute stage.
// Operand data is forwarded from the write-back bus both when a new instruction is captured
// and while the stage is stalled, so a held instruction never carries stale register data.
//
// Ports
//   ie_clk, ie_rst           clock; asynchronous active-high reset
//   ie_stall, ie_flush       hold contents / load a bubble (flush wins)
//   ie_valid_in              decode slot holds a real instruction
//   ie_pc_in, ie_imm_in      PC+4 and sign-extended immediate
//   ie_rs_data_in, ie_rt_data_in              register-file read data
//   ie_rs_addr_in, ie_rt_addr_in, ie_rd_addr_in instruction register fields
//   ie_alu_op_in             ALU operation code
//   ie_ctrl_in               {reg_wr, mem_rd, mem_wr, mem_to_reg, alu_src, reg_dst}
//   ie_wb_wr_en, ie_wb_addr, ie_wb_data        write-back bus into the register file
//   ie_*_out                 registered copies for the execute stage
//   ie_wr_addr_out           destination register (rd when reg_dst, else rt)
//   ie_load_use              combinational load-use hazard request back to decode

`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif

module id_ex_stage #(
    parameter int unsigned DWIDTH = `DWIDTH,
    parameter int unsigned AWIDTH = `AWIDTH
) (
    input  logic              ie_clk,
    input  logic              ie_rst,
    input  logic              ie_stall,
    input  logic              ie_flush,
    input  logic              ie_valid_in,
    input  logic [DWIDTH-1:0] ie_pc_in,
    input  logic [DWIDTH-1:0] ie_imm_in,
    input  logic [DWIDTH-1:0] ie_rs_data_in,
    input  logic [DWIDTH-1:0] ie_rt_data_in,
    input  logic [AWIDTH-1:0] ie_rs_addr_in,
    input  logic [AWIDTH-1:0] ie_rt_addr_in,
    input  logic [AWIDTH-1:0] ie_rd_addr_in,
    input  logic [3:0]        ie_alu_op_in,
    input  logic [5:0]        ie_ctrl_in,
    input  logic              ie_wb_wr_en,
    input  logic [AWIDTH-1:0] ie_wb_addr,
    input  logic [DWIDTH-1:0] ie_wb_data,
    output logic              ie_valid_out,
    output logic [DWIDTH-1:0] ie_pc_out,
    output logic [DWIDTH-1:0] ie_imm_out,
    output logic [DWIDTH-1:0] ie_rs_data_out,
    output logic [DWIDTH-1:0] ie_rt_data_out,
    output logic [AWIDTH-1:0] ie_rs_addr_out,
    output logic [AWIDTH-1:0] ie_rt_addr_out,
    output logic [AWIDTH-1:0] ie_wr_addr_out,
    output logic [3:0]        ie_alu_op_out,
    output logic [5:0]        ie_ctrl_out,
    output logic              ie_load_use
);

    localparam int unsigned CtrlMemRd  = 4;
    localparam int unsigned CtrlRegDst = 0;

    // Operand selection for a fresh capture: the register file is written on the same edge,
    // so a matching write-back must be taken from the bus. Address 0 is an ordinary register.
    logic [DWIDTH-1:0] rs_load_data;
    logic [DWIDTH-1:0] rt_load_data;
    logic [AWIDTH-1:0] wr_addr_sel;

    // Hold-refresh while stalled: track write-backs to the registers already held.
    logic              rs_refresh;
    logic              rt_refresh;

    always_comb begin
        rs_load_data = ie_rs_data_in;
        rt_load_data = ie_rt_data_in;
        if (ie_wb_wr_en && (ie_wb_addr == ie_rs_addr_in)) begin
            rs_load_data = ie_wb_data;
        end
        if (ie_wb_wr_en && (ie_wb_addr == ie_rt_addr_in)) begin
            rt_load_data = ie_wb_data;
        end
        wr_addr_sel = ie_ctrl_in[CtrlRegDst] ? ie_rd_addr_in : ie_rt_addr_in;
        rs_refresh  = ie_wb_wr_en && (ie_wb_addr == ie_rs_addr_out);
        rt_refresh  = ie_wb_wr_en && (ie_wb_addr == ie_rt_addr_out);
    end

    always_ff @(posedge ie_clk or posedge ie_rst) begin
        if (ie_rst) begin
            ie_valid_out   <= 1'b0;
            ie_pc_out      <= '0;
            ie_imm_out     <= '0;
            ie_rs_data_out <= '0;
            ie_rt_data_out <= '0;
            ie_rs_addr_out <= '0;
            ie_rt_addr_out <= '0;
            ie_wr_addr_out <= '0;
            ie_alu_op_out  <= '0;
            ie_ctrl_out    <= '0;
        end else if (ie_flush) begin
            // Bubble: identical to the reset image.
            ie_valid_out   <= 1'b0;
            ie_pc_out      <= '0;
            ie_imm_out     <= '0;
            ie_rs_data_out <= '0;
            ie_rt_data_out <= '0;
            ie_rs_addr_out <= '0;
            ie_rt_addr_out <= '0;
            ie_wr_addr_out <= '0;
            ie_alu_op_out  <= '0;
            ie_ctrl_out    <= '0;
        end else if (ie_stall) begin
            if (rs_refresh) begin
                ie_rs_data_out <= ie_wb_data;
            end
            if (rt_refresh) begin
                ie_rt_data_out <= ie_wb_data;
            end
        end else begin
            ie_valid_out   <= ie_valid_in;
            ie_pc_out      <= ie_pc_in;
            ie_imm_out     <= ie_imm_in;
            ie_rs_data_out <= rs_load_data;
            ie_rt_data_out <= rt_load_data;
            ie_rs_addr_out <= ie_rs_addr_in;
            ie_rt_addr_out <= ie_rt_addr_in;
            ie_wr_addr_out <= wr_addr_sel;
            ie_alu_op_out  <= ie_alu_op_in;
            ie_ctrl_out    <= ie_ctrl_in;
        end
    end

    // Deliberately independent of stall/flush: decode derives its stall from this signal.
    always_comb begin
        ie_load_use = 1'b0;
        if (!ie_rst && ie_valid_out && ie_ctrl_out[CtrlMemRd] && ie_valid_in) begin
            ie_load_use = (ie_wr_addr_out == ie_rs_addr_in) ||
                          (ie_wr_addr_out == ie_rt_addr_in);
        end
    end

endmodule
